ahb_sram_slave: RTL and testbench

AHB2 slave that sits directly downstream of the AHB interface bundle, at the end opposite the master driver. It decodes address-phase controls, inserts a configurable number of wait states, and serves byte, halfword and word reads and writes to a word-organised internal SRAM. Illegal transfers get the two-cycle ERROR response that the interface assertions (error-then-IDLE, IDLE-gives-OKAY, size alignment) expect.

---
 rtl/ahb_sram_slave.sv | 195 +++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB2 slave serving byte/halfword/word reads and writes to a word-organised SRAM.
// Illegal transfers get a two-cycle ERROR response. Legal transfers take WAIT_STATES
// HREADYOUT-low cycles before the completing data-phase cycle.
// The SRAM is split into four byte-lane RAMs. Each lane has a registered read.
// A read that directly follows a write to the same word is served by forwarding.
module ahb_sram_slave #(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int         IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [2:0] WAIT_LAST  = 3'(WAIT_STATES);
   localparam logic [1:0] RESP_OKAY  = 2'd0;
   localparam logic [1:0] RESP_ERROR = 2'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       wait_cnt_reg, wait_cnt_next;

   // Control captured at acceptance, used during the data phase.
   logic [IDX_W-1:0] idx_reg;
   logic             write_reg;
   logic [3:0]       lanes_reg;

   // Per-lane forwarding from a write that commits on the same edge a read is accepted.
   logic [3:0]       fwd_reg;
   logic [31:0]      fwd_data_reg;

   logic             accept_window;
   logic             accept;
   logic             illegal;
   logic             in_range;
   logic             rd_en;
   logic             wr_commit;
   logic             fwd_hit;
   logic [3:0]       lanes;
   logic [IDX_W-1:0] idx;
   logic [31:0]      mem_word;

   // HBURST and the SEQ/NONSEQ distinction do not affect this slave.
   logic             unused_ok;
   assign unused_ok = ^{HBURST, HTRANS[0]};

   // A new address phase is only considered when the previous data phase is completing.
   assign accept_window = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                          (state_reg == ST_ERR2);
   assign accept        = accept_window && HSEL && HREADY && HTRANS[1];
   assign idx           = HADDR[IDX_W+1:2];
   assign in_range      = ({2'b00, HADDR[31:2]} < 32'(MEM_DEPTH));
   assign rd_en         = accept && !illegal;
   assign wr_commit     = (state_reg == ST_DONE) && write_reg;
   assign fwd_hit       = wr_commit && (idx_reg == idx);

   // Decode byte lanes and legality of the address-phase size/alignment/range.
   always_comb begin
      illegal = !in_range;
      lanes   = 4'b0000;
      case (HSIZE)
         3'd0: lanes = 4'b0001 << HADDR[1:0];
         3'd1: begin
            lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            if (HADDR[0]) begin
               illegal = 1'b1;
            end
         end
         3'd2: begin
            lanes = 4'b1111;
            if (HADDR[1:0] != 2'b00) begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   // State and wait counter. Reset abandons any transfer in flight.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 3'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Latch transfer control and the forwarding decision when a legal transfer is accepted.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         idx_reg      <= '0;
         write_reg    <= 1'b0;
         lanes_reg    <= 4'b0000;
         fwd_reg      <= 4'b0000;
         fwd_data_reg <= 32'd0;
      end else if (rd_en) begin
         idx_reg      <= idx;
         write_reg    <= HWRITE;
         lanes_reg    <= lanes;
         fwd_reg      <= fwd_hit ? lanes_reg : 4'b0000;
         fwd_data_reg <= HWDATA;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_DEPTH];
         logic [7:0] rd_byte_reg;

         // Byte-lane RAM. Writes commit at the closing edge of a write DONE cycle.
         // Reads are registered at acceptance and return the old value on a same-edge write.
         always_ff @(posedge HCLK) begin
            if (wr_commit && lanes_reg[gi]) begin
               lane_mem[idx_reg] <= HWDATA[gi*8 +: 8];
            end
            if (rd_en) begin
               rd_byte_reg <= lane_mem[idx];
            end
         end

         assign mem_word[gi*8 +: 8] = fwd_reg[gi] ? fwd_data_reg[gi*8 +: 8] : rd_byte_reg;
      end
   endgenerate

   // Next-state logic and bus outputs. All outputs decode from the state register,
   // so they take their reset values as soon as reset asserts.
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      HREADYOUT     = 1'b1;
      HRESP         = RESP_OKAY;
      HRDATA        = 32'd0;
      case (state_reg)
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_cnt_reg >= WAIT_LAST) begin
               state_next    = ST_DONE;
               wait_cnt_next = 3'd0;
            end else begin
               wait_cnt_next = wait_cnt_reg + 3'd1;
            end
         end
         ST_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = RESP_ERROR;
            state_next = ST_ERR2;
         end
         default: begin
            // IDLE, DONE and ERR2 all complete a data phase this cycle
            // and may accept the next address phase.
            if (state_reg == ST_ERR2) begin
               HRESP = RESP_ERROR;
            end
            if ((state_reg == ST_DONE) && !write_reg) begin
               HRDATA = mem_word;
            end
            if (accept) begin
               if (illegal) begin
                  state_next = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next    = ST_WAIT;
                  wait_cnt_next = 3'd1;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Testbench for ahb_sram_slave.
// Two slave instances share one AHB bus: slave A has one wait state and slave B has none.
// A pipelined master plays directed transfer tables. Each transfer carries its expected
// response, which is queued when the transfer enters its data phase. A separate monitor
// compares the response when that data phase completes.
module tb_ahb_sram_slave;

   localparam int MEM_DEPTH = 256;

   logic        hclk    = 1'b0;
   logic        hresetn = 1'b0;
   logic        hsel_a, hsel_b;
   logic        hready;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        ro_a, ro_b;
   logic [1:0]  resp_a, resp_b, hresp;
   logic [31:0] rdata_a, rdata_b, hrdata;

   // Selects which slave owns the current data phase.
   logic        data_tgt     = 1'b0;
   logic        dphase_valid = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string       name;
      bit          tgt;
      bit          sel;
      logic [1:0]  trans;
      bit          write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ewaits;
      logic [1:0]  eresp;
      logic [31:0] erdata;
      bit          filler;
   } item_t;

   item_t stim_q[$];
   item_t exp_q[$];

   always #5 hclk = ~hclk;

   // The bus returns the response of the slave that owns the data phase.
   assign hready = data_tgt ? ro_b   : ro_a;
   assign hresp  = data_tgt ? resp_b : resp_a;
   assign hrdata = data_tgt ? rdata_b : rdata_a;

   ahb_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(1)) dut_a (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HREADY(hready),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HADDR(haddr), .HWDATA(hwdata),
      .HREADYOUT(ro_a), .HRESP(resp_a), .HRDATA(rdata_a)
   );

   ahb_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) dut_b (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HREADY(hready),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HADDR(haddr), .HWDATA(hwdata),
      .HREADYOUT(ro_b), .HRESP(resp_b), .HRDATA(rdata_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic item_t mk(input string name, input bit tgt, input bit sel,
                                input logic [1:0] trans, input bit write,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ewaits,
                                input logic [1:0] eresp, input logic [31:0] erdata);
      item_t it;
      it.name   = name;
      it.tgt    = tgt;
      it.sel    = sel;
      it.trans  = trans;
      it.write  = write;
      it.size   = size;
      it.addr   = addr;
      it.wdata  = wdata;
      it.ewaits = ewaits;
      it.eresp  = eresp;
      it.erdata = erdata;
      it.filler = 1'b0;
      return it;
   endfunction

   function automatic item_t filler_item();
      item_t it;
      it        = mk("filler", 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0);
      it.filler = 1'b1;
      return it;
   endfunction

   function automatic item_t next_item();
      if (stim_q.size() > 0) begin
         return stim_q.pop_front();
      end
      return filler_item();
   endfunction

   task automatic drive_addr(input item_t it);
      hsel_a = it.sel && !it.tgt;
      hsel_b = it.sel && it.tgt;
      htrans = it.trans;
      hwrite = it.write;
      hsize  = it.size;
      haddr  = it.addr;
      hburst = (it.trans == 2'd3) ? 3'd1 : 3'd0;
   endtask

   // Pipelined master. The address phase advances only when HREADY was high at the edge.
   // Returns once the stimulus queue has drained and the last data phase has completed.
   task automatic run_queue();
      item_t cur;
      logic  hr;
      int    guard;
      guard = 0;
      cur   = next_item();
      drive_addr(cur);
      forever begin
         @(negedge hclk);
         hr = hready;
         @(posedge hclk);
         #1;
         guard++;
         if (hr) begin
            if (cur.filler && (stim_q.size() == 0)) begin
               dphase_valid = 1'b0;
               return;
            end
            if (!cur.filler) begin
               exp_q.push_back(cur);
            end
            dphase_valid = !cur.filler;
            data_tgt     = cur.tgt;
            hwdata       = cur.wdata;
            cur          = next_item();
            drive_addr(cur);
         end
         if (guard > 400) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL run_queue_timeout: got %0d cycles required at most 400", guard);
            dphase_valid = 1'b0;
            stim_q.delete();
            return;
         end
      end
   endtask

   // Monitor: counts HREADY-low cycles of each data phase and compares the completed
   // response against the expected entry queued for that transfer.
   initial begin : monitor
      int         waits;
      logic [1:0] low_resp;
      item_t      e;
      waits    = 0;
      low_resp = 2'b11;
      forever begin
         @(negedge hclk);
         if (dphase_valid) begin
            if (!hready) begin
               if (waits == 0) begin
                  low_resp = hresp;
               end
               waits++;
            end else begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL unexpected_response: got resp=%0d with 0 expected entries", hresp);
               end else begin
                  e = exp_q.pop_front();
                  $display("[TB] %s: waits=%0d resp=%0d rdata=%08h", e.name, waits, hresp, hrdata);
                  check({e.name, ".waits"}, 32'(waits), 32'(e.ewaits));
                  if (e.ewaits > 0) begin
                     check({e.name, ".wait_resp"}, 32'(low_resp), 32'(e.eresp));
                  end
                  check({e.name, ".resp"}, 32'(hresp), 32'(e.eresp));
                  check({e.name, ".rdata"}, hrdata, e.erdata);
               end
               waits    = 0;
               low_resp = 2'b11;
            end
         end
      end
   end

   // Watchdog so the run always ends by itself.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL global_timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

   initial begin : main
      drive_addr(filler_item());
      hwdata  = 32'd0;
      hresetn = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      check("reset.ready_a", 32'(ro_a), 32'd1);
      check("reset.resp_a", 32'(resp_a), 32'd0);
      check("reset.rdata_a", rdata_a, 32'd0);
      check("reset.ready_b", 32'(ro_b), 32'd1);
      @(posedge hclk);
      #1;
      hresetn = 1'b1;

      // Known value at 0x30 before the interrupted write.
      stim_q.push_back(mk("pre_w30", 0, 1, 2'd2, 1, 3'd2, 32'h30, 32'h1111_1111, 1, 2'd0, 32'd0));
      run_queue();

      // Interrupted write to 0x30: assert reset during its wait cycle.
      @(posedge hclk);
      #1;
      hsel_a = 1'b1;
      htrans = 2'd2;
      hwrite = 1'b1;
      hsize  = 3'd2;
      haddr  = 32'h30;
      @(posedge hclk);
      #1;
      drive_addr(filler_item());
      hwdata = 32'h2222_2222;
      #2;
      check("rst_mid.in_wait_ready", 32'(ro_a), 32'd0);
      hresetn = 1'b0;
      #1;
      check("rst_mid.ready", 32'(ro_a), 32'd1);
      check("rst_mid.resp", 32'(resp_a), 32'd0);
      check("rst_mid.rdata", rdata_a, 32'd0);
      @(posedge hclk);
      #1;
      hresetn = 1'b1;

      // Slave A: one wait state.
      stim_q.push_back(mk("rst_rd30", 0, 1, 2'd2, 0, 3'd2, 32'h30, 32'd0, 1, 2'd0, 32'h1111_1111));
      stim_q.push_back(mk("w10",      0, 1, 2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1, 2'd0, 32'd0));
      stim_q.push_back(mk("r10",      0, 1, 2'd2, 0, 3'd2, 32'h10, 32'd0, 1, 2'd0, 32'hDEAD_BEEF));
      stim_q.push_back(mk("w20",      0, 1, 2'd2, 1, 3'd2, 32'h20, 32'h0000_0000, 1, 2'd0, 32'd0));
      stim_q.push_back(mk("b22",      0, 1, 2'd2, 1, 3'd0, 32'h22, 32'h00AB_0000, 1, 2'd0, 32'd0));
      stim_q.push_back(mk("r20a",     0, 1, 2'd2, 0, 3'd2, 32'h20, 32'd0, 1, 2'd0, 32'h00AB_0000));
      stim_q.push_back(mk("h22",      0, 1, 2'd2, 1, 3'd1, 32'h22, 32'h1234_ABCD, 1, 2'd0, 32'd0));
      stim_q.push_back(mk("r20b",     0, 1, 2'd2, 0, 3'd2, 32'h20, 32'd0, 1, 2'd0, 32'h1234_0000));
      stim_q.push_back(mk("w00",      0, 1, 2'd2, 1, 3'd2, 32'h00, 32'h0BAD_F00D, 1, 2'd0, 32'd0));
      stim_q.push_back(mk("e_align",  0, 1, 2'd2, 1, 3'd2, 32'h02, 32'hFFFF_FFFF, 1, 2'd1, 32'd0));
      stim_q.push_back(mk("idle1",    0, 1, 2'd0, 0, 3'd2, 32'h00, 32'd0, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("e_range",  0, 1, 2'd2, 1, 3'd2, 32'(MEM_DEPTH * 4), 32'hFFFF_FFFF, 1, 2'd1, 32'd0));
      stim_q.push_back(mk("idle2",    0, 1, 2'd0, 0, 3'd2, 32'h00, 32'd0, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("e_size",   0, 1, 2'd2, 1, 3'd3, 32'h00, 32'hFFFF_FFFF, 1, 2'd1, 32'd0));
      stim_q.push_back(mk("idle3",    0, 1, 2'd0, 0, 3'd2, 32'h00, 32'd0, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("e_half",   0, 1, 2'd2, 1, 3'd1, 32'h21, 32'hFFFF_FFFF, 1, 2'd1, 32'd0));
      stim_q.push_back(mk("busy",     0, 1, 2'd1, 1, 3'd2, 32'h00, 32'hFFFF_FFFF, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("r00",      0, 1, 2'd2, 0, 3'd2, 32'h00, 32'd0, 1, 2'd0, 32'h0BAD_F00D));
      stim_q.push_back(mk("r20c",     0, 1, 2'd2, 0, 3'd2, 32'h20, 32'd0, 1, 2'd0, 32'h1234_0000));
      stim_q.push_back(mk("nosel_w",  0, 0, 2'd2, 1, 3'd2, 32'h10, 32'h0000_0000, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("r10b",     0, 1, 2'd2, 0, 3'd2, 32'h10, 32'd0, 1, 2'd0, 32'hDEAD_BEEF));
      run_queue();

      // Slave B: zero wait states with back-to-back pipelining.
      stim_q.push_back(mk("b_w40",  1, 1, 2'd2, 1, 3'd2, 32'h40, 32'h0000_0055, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("b_r40",  1, 1, 2'd3, 0, 3'd2, 32'h40, 32'd0, 0, 2'd0, 32'h0000_0055));
      stim_q.push_back(mk("b_w44",  1, 1, 2'd2, 1, 3'd2, 32'h44, 32'h0102_0304, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("b_b47",  1, 1, 2'd3, 1, 3'd0, 32'h47, 32'hEE00_0000, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("b_r44",  1, 1, 2'd3, 0, 3'd2, 32'h44, 32'd0, 0, 2'd0, 32'hEE02_0304));
      stim_q.push_back(mk("b_e46",  1, 1, 2'd2, 0, 3'd2, 32'h46, 32'd0, 1, 2'd1, 32'd0));
      stim_q.push_back(mk("b_idle", 1, 1, 2'd0, 0, 3'd2, 32'h00, 32'd0, 0, 2'd0, 32'd0));
      stim_q.push_back(mk("b_r40b", 1, 1, 2'd2, 0, 3'd2, 32'h40, 32'd0, 0, 2'd0, 32'h0000_0055));
      run_queue();

      repeat (2) @(posedge hclk);
      check("pending_expected", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
